vector_recorder: RTL and testbench

- Synthesizable capture buffer. Samples a DUT's input/output vector (e.g. {a,b,s,y} of a 2:1 mux) on a capture strobe and stores it in order.
- Later streams the stored vectors out with a valid/ready handshake, in the same {inputs, output} word layout the benches load from data.tv.
- Acts as the writer side of the test-vector flow: it produces vector files, while the benches consume them.
- Sits beside a DUT on the board or in simulation; the dump port feeds a UART/printer or a bench monitor.

---
 rtl/vector_recorder.sv | 130 +++++++++++++
 tb/tb_vector_recorder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_recorder.sv
// Capture buffer: records cap_vec words on cap_en, then streams them out with valid/ready.
// Define REC_OVF_CNT_EN to build the saturating dropped-capture counter on ovf_cnt.
module vector_recorder #(
  parameter int VEC_W  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [VEC_W-1:0]  cap_vec,
  input  logic              dump_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_vec,
  output logic              out_last,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic              busy,
  output logic [15:0]       ovf_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DUMP = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [VEC_W-1:0]  mem [DEPTH];

  logic              cap_ok;
  logic              cap_drop;
  logic              handshake;
  logic [ADDR_W:0]   count_after;

  assign busy      = (state_q == DUMP);
  assign out_valid = busy;
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_vec   = mem[rd_ptr_q];
  assign out_last  = busy && ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
  assign handshake = out_valid && out_ready;

  // Captures are only honoured in IDLE; during a dump the contents stay frozen.
  assign cap_ok      = (state_q == IDLE) && cap_en && !full;
  assign cap_drop    = (state_q == IDLE) && cap_en && full;
  assign count_after = count_q + {{ADDR_W{1'b0}}, cap_ok};

  // NOTE: every next-state signal gets its default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (cap_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (cap_drop) overflow_d = 1'b1;
        count_d = count_after;
        // A same-cycle capture is included in the dump.
        if (dump_start && (count_after != '0)) begin
          state_d  = DUMP;
          rd_ptr_d = '0;
        end
      end
      DUMP: begin
        if (handshake) begin
          if (out_last) begin
            state_d  = IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (cap_ok) mem[wr_ptr_q] <= cap_vec;
  end

`ifdef REC_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt_q <= '0;
    end else if (cap_drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vector_recorder.sv
// Scoreboard bench for vector_recorder: directed captures push expected dump words,
// an independent monitor pops and compares on every handshake.
module tb_vector_recorder;

  localparam int VEC_W  = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

`ifdef REC_OVF_CNT_EN
  localparam logic [15:0] EXP_OVF_CNT = 16'd1;
`else
  localparam logic [15:0] EXP_OVF_CNT = 16'd0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cap_en;
  logic [VEC_W-1:0]  cap_vec;
  logic              dump_start;
  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_vec;
  logic              out_last;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic              busy;
  logic [15:0]       ovf_cnt;

  vector_recorder #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_en     (cap_en),
    .cap_vec    (cap_vec),
    .dump_start (dump_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_last   (out_last),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .busy       (busy),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected dump words as {last, vec}.
  logic [VEC_W:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Handshakes are sampled on the falling edge, i.e. the state the next rising edge will see.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {27'd0, out_last, out_vec}, 32'hDEAD);
      end else begin
        logic [VEC_W:0] e;
        e = exp_q.pop_front();
        check("dump_vec",  {28'd0, out_vec}, {28'd0, e[VEC_W-1:0]});
        check("dump_last", {31'd0, out_last}, {31'd0, e[VEC_W]});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [VEC_W-1:0] v);
    cap_en  = 1'b1;
    cap_vec = v;
    cycle();
    cap_en  = 1'b0;
  endtask

  task automatic pulse_dump();
    dump_start = 1'b1;
    cycle();
    dump_start = 1'b0;
  endtask

  task automatic expect_word(input logic [VEC_W-1:0] v, input logic last);
    exp_q.push_back({last, v});
  endtask

  task automatic wait_idle(input int max_cycles, output int n);
    n = 0;
    while (busy && n < max_cycles) begin
      cycle();
      n++;
    end
    if (busy) check("dump_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #12;
    reset = 1'b1;
    cycle();
  endtask

  int n;

  initial begin
    reset      = 1'b0;
    cap_en     = 1'b0;
    cap_vec    = '0;
    dump_start = 1'b0;
    out_ready  = 1'b1;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count",     {27'd0, count},     32'd0);
    check("rst_full",      {31'd0, full},      32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_ovf_cnt",   {16'd0, ovf_cnt},   32'd0);
    #10;
    reset = 1'b1;
    cycle();

    // Basic capture and dump
    capture(4'b1011);
    capture(4'b0100);
    capture(4'b1110);
    check("basic_count", {27'd0, count}, 32'd3);
    expect_word(4'b1011, 1'b0);
    expect_word(4'b0100, 1'b0);
    expect_word(4'b1110, 1'b1);
    pulse_dump();
    check("basic_busy", {31'd0, busy}, 32'd1);
    wait_idle(20, n);
    check("basic_dump_cycles", n, 32'd3);
    check("basic_count_after", {27'd0, count}, 32'd0);
    check("basic_busy_after",  {31'd0, busy},  32'd0);

    // Empty dump is ignored
    pulse_dump();
    check("empty_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("empty_valid_later", {31'd0, out_valid}, 32'd0);

    // Capture attempted during a dump is neither stored nor an overflow
    capture(4'h1);
    capture(4'h2);
    out_ready = 1'b0;
    pulse_dump();
    cap_en  = 1'b1;
    cap_vec = 4'hF;
    cycle();
    cycle();
    cap_en  = 1'b0;
    check("capdump_count",    {27'd0, count},    32'd2);
    check("capdump_overflow", {31'd0, overflow}, 32'd0);
    expect_word(4'h1, 1'b0);
    expect_word(4'h2, 1'b1);
    out_ready = 1'b1;
    wait_idle(20, n);
    check("capdump_overflow_after", {31'd0, overflow}, 32'd0);

    // Backpressure: two-word dump with three stalled cycles
    capture(4'h9);
    capture(4'h6);
    out_ready = 1'b0;
    pulse_dump();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_vec",   {28'd0, out_vec},   32'h9);
      check("bp_last",  {31'd0, out_last},  32'd0);
      cycle();
    end
    expect_word(4'h9, 1'b0);
    expect_word(4'h6, 1'b1);
    out_ready = 1'b1;
    wait_idle(20, n);
    check("bp_count_after", {27'd0, count}, 32'd0);

    // Simultaneous capture and dump request
    capture(4'h3);
    cap_en     = 1'b1;
    cap_vec    = 4'b0111;
    dump_start = 1'b1;
    cycle();
    cap_en     = 1'b0;
    dump_start = 1'b0;
    expect_word(4'h3, 1'b0);
    expect_word(4'b0111, 1'b1);
    wait_idle(20, n);
    check("simul_dump_cycles", n, 32'd2);

    // Full and overflow: 17 captures, the last one dropped
    for (int i = 0; i < 17; i++) capture(VEC_W'(i));
    check("full_count",    {27'd0, count},    32'd16);
    check("full_flag",     {31'd0, full},     32'd1);
    check("full_overflow", {31'd0, overflow}, 32'd1);
    check("full_ovf_cnt",  {16'd0, ovf_cnt},  {16'd0, EXP_OVF_CNT});
    for (int i = 0; i < 16; i++) expect_word(VEC_W'(i), i == 15);
    pulse_dump();
    wait_idle(40, n);
    check("full_dump_cycles",    n, 32'd16);
    check("full_flag_after",     {31'd0, full},     32'd0);
    check("full_overflow_kept",  {31'd0, overflow}, 32'd1);

    // Reset in the middle of a three-word dump
    do_reset();
    check("rst2_overflow", {31'd0, overflow}, 32'd0);
    capture(4'hA);
    capture(4'hB);
    capture(4'hC);
    expect_word(4'hA, 1'b0);
    expect_word(4'hB, 1'b0);
    expect_word(4'hC, 1'b1);
    pulse_dump();
    cycle();
    check("mid_words_left", exp_q.size(), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_count",     {27'd0, count},     32'd0);
    check("mid_busy",      {31'd0, busy},      32'd0);
    check("mid_out_last",  {31'd0, out_last},  32'd0);
    #10;
    reset = 1'b1;
    cycle();
    cycle();
    check("mid_valid_after", {31'd0, out_valid}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
